// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution front end: default geometry,
// counter widths, window count per map and the pixel type.
package conv_pkg;

  localparam int CONV_WI    = 8;
  localparam int CONV_IMG_W = 28;
  localparam int CONV_IMG_H = 28;

  localparam int COL_W   = $clog2(CONV_IMG_W);
  localparam int ROW_W   = $clog2(CONV_IMG_H);
  localparam int NUM_WIN = (CONV_IMG_W - 2) * (CONV_IMG_H - 2);

  typedef logic [CONV_WI-1:0] pixel_t;

  // Valid (unpadded) 3x3 windows in a w x h map.
  function automatic int num_windows(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Fixed-length pixel delay line: a circular RAM of DEPTH entries with a single
// pointer. Each enabled cycle the entry under the pointer is presented on
// oData (the pixel written DEPTH enables ago) and overwritten with iData.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int WI    = CONV_WI,
  parameter int DEPTH = CONV_IMG_W
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iEn,
  input  logic [WI-1:0] iData,
  output logic [WI-1:0] oData
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WI-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  // Read-before-write: the old entry leaves as the new one arrives.
  assign oData = mem[ptr];

  // Store the incoming pixel at the current slot.
  // NOTE: the RAM has no reset; its contents are masked until a full row has
  // been rewritten, and a reset term would stop it mapping onto RAM cells.
  always_ff @(posedge iClk) begin
    if (iEn) mem[ptr] <= iData;
  end

  // Advance the circular pointer on every accepted pixel.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ptr <= '0;
    end else if (iEn) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Raster-scan 3x3 sliding-window generator feeding four_conv3x3_kernel.
// Two cascaded line buffers supply rows r-1 and r-2 for the column being
// accepted; three 3-deep shift registers form the window. A window is valid
// one cycle after pixel (r,c) with r>=2 and c>=2 is accepted, and a map-done
// pulse follows the last window of each map by one cycle.
// Optional build macro: WINGEN_PHASE_EN adds oPhase, a mod-4 count of
// completed maps that steps in the same cycle as oMapDone.
module conv3x3_window_gen
  import conv_pkg::*;
#(
  parameter int WI    = CONV_WI,
  parameter int IMG_W = CONV_IMG_W,
  parameter int IMG_H = CONV_IMG_H
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iSoftClr,
  input  logic            iPixValid,
  input  logic [WI-1:0]   iPixData,
  output logic [3*WI-1:0] oWindowInRow1,
  output logic [3*WI-1:0] oWindowInRow2,
  output logic [3*WI-1:0] oWindowInRow3,
  output logic            oInValid,
  output logic            oMapDone
`ifdef WINGEN_PHASE_EN
  ,
  output logic [1:0]      oPhase
`endif
);

  localparam int COL_BITS = $clog2(IMG_W);
  localparam int ROW_BITS = $clog2(IMG_H);

  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic                accept;
  logic                col_last;
  logic                row_last;
  logic                win_ok;
  logic                last_acc;
  logic [WI-1:0]       lb1_out;
  logic [WI-1:0]       lb2_out;

  // A soft clear wins over a simultaneous pixel, which is dropped.
  assign accept   = iPixValid & ~iSoftClr;
  assign col_last = (col == COL_BITS'(IMG_W - 1));
  assign row_last = (row == ROW_BITS'(IMG_H - 1));
  // Columns 0 and 1 hold the previous row's tail in the shift registers.
  assign win_ok   = (row >= ROW_BITS'(2)) && (col >= COL_BITS'(2));

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      col <= '0;
      row <= '0;
    end else if (iSoftClr) begin
      col <= '0;
      row <= '0;
    end else if (iPixValid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Row r-1 delay line, fed by the incoming pixel.
  conv_line_buffer #(
    .WI    (WI),
    .DEPTH (IMG_W)
  ) u_lb1 (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (accept),
    .iData (iPixData),
    .oData (lb1_out)
  );

  // Row r-2 delay line, cascaded from the first.
  conv_line_buffer #(
    .WI    (WI),
    .DEPTH (IMG_W)
  ) u_lb2 (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (accept),
    .iData (lb1_out),
    .oData (lb2_out)
  );

  // Window shift registers: newest column enters at the LSB end, so the MSB
  // slice holds column c-2 (w00 ordering). Held between accepted pixels.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oWindowInRow1 <= '0;
      oWindowInRow2 <= '0;
      oWindowInRow3 <= '0;
    end else if (accept) begin
      oWindowInRow1 <= {oWindowInRow1[2*WI-1:0], lb2_out};
      oWindowInRow2 <= {oWindowInRow2[2*WI-1:0], lb1_out};
      oWindowInRow3 <= {oWindowInRow3[2*WI-1:0], iPixData};
    end
  end

  // Window valid, last-window marker and the map-done pulse one cycle later.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oInValid <= 1'b0;
      last_acc <= 1'b0;
      oMapDone <= 1'b0;
    end else if (iSoftClr) begin
      oInValid <= 1'b0;
      last_acc <= 1'b0;
      oMapDone <= 1'b0;
    end else begin
      oInValid <= accept & win_ok;
      last_acc <= accept & col_last & row_last;
      oMapDone <= last_acc;
    end
  end

`ifdef WINGEN_PHASE_EN
  // Completed-map count; steps on the same edge that raises oMapDone.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oPhase <= 2'd0;
    end else if (iSoftClr) begin
      oPhase <= 2'd0;
    end else if (last_acc) begin
      oPhase <= oPhase + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Directed bench for conv3x3_window_gen: ramp images with and without valid
// gaps, back-to-back maps, mid-map reset, soft clear with a dropped pixel, and
// a minimal 3x3 instance. Expected windows come from the ramp formula.
module tb_conv3x3_window_gen;
  import conv_pkg::*;

  localparam int W  = CONV_IMG_W;
  localparam int H  = CONV_IMG_H;
  localparam int WI = CONV_WI;

  logic            iClk = 1'b0;
  logic            iRst;
  logic            iSoftClr;
  logic            iPixValid;
  logic [WI-1:0]   iPixData;
  logic [3*WI-1:0] oWindowInRow1, oWindowInRow2, oWindowInRow3;
  logic            oInValid, oMapDone;
`ifdef WINGEN_PHASE_EN
  logic [1:0]      oPhase;
`endif

  logic            s_soft_clr, s_valid;
  logic [7:0]      s_data;
  logic [23:0]     s_row1, s_row2, s_row3;
  logic            s_in_valid, s_done;
`ifdef WINGEN_PHASE_EN
  logic [1:0]      s_phase;
`endif

  always #5 iClk = ~iClk;

  conv3x3_window_gen dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iSoftClr      (iSoftClr),
    .iPixValid     (iPixValid),
    .iPixData      (iPixData),
    .oWindowInRow1 (oWindowInRow1),
    .oWindowInRow2 (oWindowInRow2),
    .oWindowInRow3 (oWindowInRow3),
    .oInValid      (oInValid),
    .oMapDone      (oMapDone)
`ifdef WINGEN_PHASE_EN
    ,
    .oPhase        (oPhase)
`endif
  );

  conv3x3_window_gen #(.WI(8), .IMG_W(3), .IMG_H(3)) dut_small (
    .iClk          (iClk),
    .iRst          (iRst),
    .iSoftClr      (s_soft_clr),
    .iPixValid     (s_valid),
    .iPixData      (s_data),
    .oWindowInRow1 (s_row1),
    .oWindowInRow2 (s_row2),
    .oWindowInRow3 (s_row3),
    .oInValid      (s_in_valid),
    .oMapDone      (s_done)
`ifdef WINGEN_PHASE_EN
    ,
    .oPhase        (s_phase)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitors, sampled on the falling edge.
  int              cyc = 0;
  logic [3*WI-1:0] q1[$], q2[$], q3[$];
  int              done_cnt = 0;
  int              last_valid_cyc = 0;
  int              overlap_cnt = 0;
`ifdef WINGEN_PHASE_EN
  logic [1:0]      phase_q[$];
`endif
  int              s_win_cnt = 0, s_done_cnt = 0, s_last_valid = 0;
  logic [23:0]     s_w1, s_w2, s_w3;

  always @(posedge iClk) cyc++;

  always @(negedge iClk) begin
    if (oInValid) begin
      q1.push_back(oWindowInRow1);
      q2.push_back(oWindowInRow2);
      q3.push_back(oWindowInRow3);
      last_valid_cyc = cyc;
    end
    if (oMapDone) begin
      done_cnt++;
      check("map_done_lat", 64'(cyc - last_valid_cyc), 64'd1);
`ifdef WINGEN_PHASE_EN
      phase_q.push_back(oPhase);
`endif
    end
    if (oInValid && oMapDone) overlap_cnt++;
    if (s_in_valid) begin
      s_win_cnt++;
      s_w1 = s_row1;
      s_w2 = s_row2;
      s_w3 = s_row3;
      s_last_valid = cyc;
    end
    if (s_done) begin
      s_done_cnt++;
      check("small_done_lat", 64'(cyc - s_last_valid), 64'd1);
    end
  end

  function automatic logic [WI-1:0] pix(input int r, input int c);
    return WI'((r * W + c) & 255);
  endfunction

  function automatic logic [3*WI-1:0] exp_row(input int r, input int c);
    return {pix(r, c - 2), pix(r, c - 1), pix(r, c)};
  endfunction

  task automatic send(input logic [WI-1:0] d, input int gap);
    repeat (gap) begin
      @(negedge iClk);
      iPixValid = 1'b0;
    end
    @(negedge iClk);
    iPixValid = 1'b1;
    iPixData  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iClk);
      iPixValid = 1'b0;
    end
  endtask

  task automatic send_image(input int max_gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(pix(r, c), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  // Compare n windows captured from index base against the ramp sequence.
  task automatic check_seq(input string tag, input int base, input int n);
    int got_n;
    got_n = q1.size() - base;
    check({tag, "_count"}, 64'(got_n), 64'(n));
    for (int i = 0; i < n && i < got_n; i++) begin
      int k, r, c;
      k = i % NUM_WIN;
      r = 2 + k / (W - 2);
      c = 2 + k % (W - 2);
      check($sformatf("%s_w%0d_r1", tag, i), 64'(q1[base + i]), 64'(exp_row(r - 2, c)));
      check($sformatf("%s_w%0d_r2", tag, i), 64'(q2[base + i]), 64'(exp_row(r - 1, c)));
      check($sformatf("%s_w%0d_r3", tag, i), 64'(q3[base + i]), 64'(exp_row(r, c)));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_r1"}, 64'(oWindowInRow1), 64'd0);
    check({tag, "_r2"}, 64'(oWindowInRow2), 64'd0);
    check({tag, "_r3"}, 64'(oWindowInRow3), 64'd0);
    check({tag, "_valid"}, 64'(oInValid), 64'd0);
    check({tag, "_done"}, 64'(oMapDone), 64'd0);
`ifdef WINGEN_PHASE_EN
    check({tag, "_phase"}, 64'(oPhase), 64'd0);
`endif
  endtask

  initial begin
    int base;
    iRst       = 1'b1;
    iSoftClr   = 1'b0;
    iPixValid  = 1'b0;
    iPixData   = '0;
    s_soft_clr = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;

    // Reset state.
    repeat (2) @(negedge iClk);
    check_outputs_zero("reset");
    iRst = 1'b0;

    // Continuous ramp image.
    base = q1.size();
    done_cnt = 0;
    send_image(0);
    idle(5);
    check("t1_first_r1", 64'(q1[base]), 64'h000102);
    check("t1_first_r2", 64'(q2[base]), 64'h1C1D1E);
    check("t1_first_r3", 64'(q3[base]), 64'h38393A);
    check_seq("t1", base, NUM_WIN);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    // Same image with random valid gaps.
    base = q1.size();
    done_cnt = 0;
    send_image(3);
    idle(5);
    check_seq("t2", base, NUM_WIN);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);

    // Soft clear while idle, then four maps back to back.
    @(negedge iClk);
    iSoftClr = 1'b1;
    @(negedge iClk);
    iSoftClr = 1'b0;
`ifdef WINGEN_PHASE_EN
    check("t3_phase_clr", 64'(oPhase), 64'd0);
    phase_q.delete();
`endif
    base = q1.size();
    done_cnt = 0;
    repeat (4) send_image(0);
    idle(5);
    check_seq("t3", base, 4 * num_windows(W, H));
    check("t3_done_cnt", 64'(done_cnt), 64'd4);
`ifdef WINGEN_PHASE_EN
    check("t3_phase_n", 64'(phase_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < phase_q.size(); i++)
      check($sformatf("t3_phase_%0d", i), 64'(phase_q[i]), 64'((i + 1) % 4));
`endif

    // Asynchronous reset after pixel (10,5), then restart the image.
    done_cnt = 0;
    for (int r = 0; r <= 10; r++)
      for (int c = 0; c < W && !(r == 10 && c > 5); c++)
        send(pix(r, c), 0);
    @(negedge iClk);
    iPixValid = 1'b0;
    iRst      = 1'b1;
    #1;
    check_outputs_zero("t4_rst_async");
    @(negedge iClk);
    check_outputs_zero("t4_rst_held");
    iRst = 1'b0;
    #1;
    base = q1.size();
    send_image(0);
    idle(5);
    check("t4_first_r1", 64'(q1[base]), 64'h000102);
    check("t4_first_r3", 64'(q3[base]), 64'h38393A);
    check_seq("t4", base, NUM_WIN);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);

    // Soft clear together with pixel (3,3): that pixel is dropped.
    done_cnt = 0;
    for (int r = 0; r <= 3; r++)
      for (int c = 0; c < W && !(r == 3 && c > 2); c++)
        send(pix(r, c), 0);
    @(negedge iClk);
    iSoftClr  = 1'b1;
    iPixValid = 1'b1;
    iPixData  = 8'hEE;
    @(negedge iClk);
    iSoftClr  = 1'b0;
    iPixValid = 1'b0;
    check("t5_clr_valid", 64'(oInValid), 64'd0);
    check("t5_clr_done", 64'(oMapDone), 64'd0);
    #1;
    base = q1.size();
    send_image(0);
    idle(5);
    check_seq("t5", base, NUM_WIN);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);

    // Minimal 3x3 instance: one window equal to the whole image.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        @(negedge iClk);
        s_valid = 1'b1;
        s_data  = 8'(8'h10 + r * 3 + c);
      end
    @(negedge iClk);
    s_valid = 1'b0;
    repeat (4) @(negedge iClk);
    check("small_win_cnt", 64'(s_win_cnt), 64'd1);
    check("small_r1", 64'(s_w1), 64'h101112);
    check("small_r2", 64'(s_w2), 64'h131415);
    check("small_r3", 64'(s_w3), 64'h161718);
    check("small_done_cnt", 64'(s_done_cnt), 64'd1);

    check("no_valid_done_overlap", 64'(overlap_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
